// File: rtl/hazard_scoreboard_if.sv
// Decode/issue/retire bundle between the pipeline (master) and the hazard scoreboard (slave).
// Issue fires on issue_valid & ~dep_stall & ~flush; retire fires on retire_valid & ~flush; neither waits on anything else.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS    = 8,
  parameter int REG_W       = $clog2(NUM_REGS),
  parameter int STALL_CNT_W = 16
);
  logic                   sr1_needed;
  logic                   sr2_needed;
  logic [REG_W-1:0]       sr1;
  logic [REG_W-1:0]       sr2;
  logic                   de_br_op;
  logic                   issue_valid;
  logic                   issue_ld_reg;
  logic                   issue_ld_cc;
  logic [REG_W-1:0]       issue_dr;
  logic                   retire_valid;
  logic                   retire_ld_reg;
  logic                   retire_ld_cc;
  logic [REG_W-1:0]       retire_dr;
  logic                   flush;
  logic                   dep_stall;
  logic [NUM_REGS-1:0]    busy_vec;
  logic                   cc_pending;
  logic                   sb_err;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output sr1_needed, sr2_needed, sr1, sr2, de_br_op,
    output issue_valid, issue_ld_reg, issue_ld_cc, issue_dr,
    output retire_valid, retire_ld_reg, retire_ld_cc, retire_dr, flush,
    input  dep_stall, busy_vec, cc_pending, sb_err, stall_cycles
  );

  modport slave (
    input  sr1_needed, sr2_needed, sr1, sr2, de_br_op,
    input  issue_valid, issue_ld_reg, issue_ld_cc, issue_dr,
    input  retire_valid, retire_ld_reg, retire_ld_cc, retire_dr, flush,
    output dep_stall, busy_vec, cc_pending, sb_err, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register and CC pending-writer counters driving the decode stall, plus a saturating stall counter.
// Optional HAZARD_RETIRE_BYPASS_EN: a last pending writer retiring this cycle does not stall decode.
module hazard_scoreboard #(
  parameter int NUM_REGS     = 8,
  parameter int REG_W        = $clog2(NUM_REGS),
  parameter int MAX_INFLIGHT = 3,
  parameter int STALL_CNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  hazard_scoreboard_if.slave sb
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]       reg_cnt [NUM_REGS];
  logic [CNT_W-1:0]       reg_nxt [NUM_REGS];
  logic [CNT_W-1:0]       cc_cnt;
  logic [CNT_W-1:0]       cc_nxt;
  logic [NUM_REGS-1:0]    reg_inc, reg_dec, reg_ovf, reg_unf;
  logic                   cc_inc, cc_dec, cc_err;
  logic                   sb_err_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   issue_fire, retire_fire, ret_reg, ret_cc;
  logic                   sr1_byp, sr2_byp, cc_byp;
  logic                   sr1_busy, sr2_busy, cc_busy, dep_stall;

  assign retire_fire = sb.retire_valid & ~sb.flush;
  assign ret_reg     = retire_fire & sb.retire_ld_reg;
  assign ret_cc      = retire_fire & sb.retire_ld_cc;

`ifdef HAZARD_RETIRE_BYPASS_EN
  // Write-through regfile: decode sees the writeback value, so the last writer retiring now is not a hazard.
  assign sr1_byp = ret_reg & (sb.retire_dr == sb.sr1) & (reg_cnt[sb.sr1] == CNT_ONE);
  assign sr2_byp = ret_reg & (sb.retire_dr == sb.sr2) & (reg_cnt[sb.sr2] == CNT_ONE);
  assign cc_byp  = ret_cc & (cc_cnt == CNT_ONE);
`else
  assign sr1_byp = 1'b0;
  assign sr2_byp = 1'b0;
  assign cc_byp  = 1'b0;
`endif

  assign sr1_busy   = (reg_cnt[sb.sr1] != '0) & ~sr1_byp;
  assign sr2_busy   = (reg_cnt[sb.sr2] != '0) & ~sr2_byp;
  assign cc_busy    = (cc_cnt != '0) & ~cc_byp;
  assign dep_stall  = (sb.sr1_needed & sr1_busy) | (sb.sr2_needed & sr2_busy) | (sb.de_br_op & cc_busy);
  assign issue_fire = sb.issue_valid & ~dep_stall & ~sb.flush;

  // Net-zero updates (inc and dec together) leave the counter alone and never flag an error.
  always_comb begin
    reg_inc = '0;
    reg_dec = '0;
    reg_ovf = '0;
    reg_unf = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_inc[i] = issue_fire & sb.issue_ld_reg & (sb.issue_dr == REG_W'(i));
      reg_dec[i] = ret_reg & (sb.retire_dr == REG_W'(i));
      reg_nxt[i] = reg_cnt[i];
      if (reg_inc[i] & ~reg_dec[i]) begin
        if (reg_cnt[i] == CNT_MAX) reg_ovf[i] = 1'b1;
        else                       reg_nxt[i] = reg_cnt[i] + CNT_ONE;
      end else if (reg_dec[i] & ~reg_inc[i]) begin
        if (reg_cnt[i] == '0) reg_unf[i] = 1'b1;
        else                  reg_nxt[i] = reg_cnt[i] - CNT_ONE;
      end
    end
  end

  always_comb begin
    cc_inc = issue_fire & sb.issue_ld_cc;
    cc_dec = ret_cc;
    cc_nxt = cc_cnt;
    cc_err = 1'b0;
    if (cc_inc & ~cc_dec) begin
      if (cc_cnt == CNT_MAX) cc_err = 1'b1;
      else                   cc_nxt = cc_cnt + CNT_ONE;
    end else if (cc_dec & ~cc_inc) begin
      if (cc_cnt == '0) cc_err = 1'b1;
      else              cc_nxt = cc_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) reg_cnt[i] <= '0;
      cc_cnt   <= '0;
      sb_err_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      // Flush drops every in-flight writer; error and perf state survive it.
      if (sb.flush) begin
        for (int i = 0; i < NUM_REGS; i++) reg_cnt[i] <= '0;
        cc_cnt <= '0;
      end else begin
        for (int i = 0; i < NUM_REGS; i++) reg_cnt[i] <= reg_nxt[i];
        cc_cnt <= cc_nxt;
      end
      if ((|reg_ovf) | (|reg_unf) | cc_err) sb_err_q <= 1'b1;
      if (dep_stall && (stall_q != '1)) stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  always_comb begin
    sb.busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) sb.busy_vec[i] = (reg_cnt[i] != '0);
  end

  assign sb.dep_stall    = dep_stall;
  assign sb.cc_pending   = (cc_cnt != '0);
  assign sb.sb_err       = sb_err_q;
  assign sb.stall_cycles = stall_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle vector table plus hand-written reset/underflow/flush sequences.
module tb_hazard_scoreboard;
  localparam int NUM_REGS    = 8;
  localparam int REG_W       = 3;
  localparam int STALL_CNT_W = 16;
  localparam int NVEC        = 36;
`ifdef HAZARD_RETIRE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int S = 4 - BYP;
  localparam int T = S + 1;
  localparam int U = T + 2 - BYP;

  typedef struct {
    logic       s1n;
    logic [2:0] s1;
    logic       s2n;
    logic [2:0] s2;
    logic       br;
    logic       iv, ild, ilc;
    logic [2:0] idr;
    logic       rv, rld, rlc;
    logic [2:0] rdr;
    logic       fl;
    logic       e_stall;
    logic [7:0] e_busy;
    logic       e_cc;
    logic       e_err;
    logic [15:0] e_sc;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t tbl [NVEC];

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .STALL_CNT_W(STALL_CNT_W)) sb_if ();

  hazard_scoreboard #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .MAX_INFLIGHT(3), .STALL_CNT_W(STALL_CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sb      (sb_if)
  );

  function automatic vec_t mk(input int s1n, s1, s2n, s2, br, iv, ild, ilc, idr,
                              input int rv, rld, rlc, rdr, fl, st, busy, cc, err, sc);
    vec_t v;
    v.s1n = s1n[0]; v.s1 = 3'(s1); v.s2n = s2n[0]; v.s2 = 3'(s2); v.br = br[0];
    v.iv = iv[0]; v.ild = ild[0]; v.ilc = ilc[0]; v.idr = 3'(idr);
    v.rv = rv[0]; v.rld = rld[0]; v.rlc = rlc[0]; v.rdr = 3'(rdr); v.fl = fl[0];
    v.e_stall = st[0]; v.e_busy = 8'(busy); v.e_cc = cc[0]; v.e_err = err[0]; v.e_sc = 16'(sc);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    sb_if.sr1_needed    = v.s1n;
    sb_if.sr1           = v.s1;
    sb_if.sr2_needed    = v.s2n;
    sb_if.sr2           = v.s2;
    sb_if.de_br_op      = v.br;
    sb_if.issue_valid   = v.iv;
    sb_if.issue_ld_reg  = v.ild;
    sb_if.issue_ld_cc   = v.ilc;
    sb_if.issue_dr      = v.idr;
    sb_if.retire_valid  = v.rv;
    sb_if.retire_ld_reg = v.rld;
    sb_if.retire_ld_cc  = v.rlc;
    sb_if.retire_dr     = v.rdr;
    sb_if.flush         = v.fl;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t v);
    check("dep_stall", idx, 32'(sb_if.dep_stall), 32'(v.e_stall));
    check("busy_vec", idx, 32'(sb_if.busy_vec), 32'(v.e_busy));
    check("cc_pending", idx, 32'(sb_if.cc_pending), 32'(v.e_cc));
    check("sb_err", idx, 32'(sb_if.sb_err), 32'(v.e_err));
    check("stall_cycles", idx, 32'(sb_if.stall_cycles), 32'(v.e_sc));
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0);
    // Each row: inputs for one cycle, then outputs expected mid-cycle (state before that cycle's edge).
    tbl[0]  = mk(1,3,0,0,0, 0,0,0,0, 0,0,0,0, 0, 0,'h00,0,0,0);
    tbl[1]  = mk(0,0,0,0,0, 1,1,0,3, 0,0,0,0, 0, 0,'h00,0,0,0);
    tbl[2]  = mk(1,3,0,0,0, 1,1,0,6, 0,0,0,0, 0, 1,'h08,0,0,0);
    tbl[3]  = mk(1,3,0,0,0, 1,1,0,6, 0,0,0,0, 0, 1,'h08,0,0,1);
    tbl[4]  = mk(1,3,0,0,0, 1,1,0,6, 0,0,0,0, 0, 1,'h08,0,0,2);
    tbl[5]  = mk(1,3,0,0,0, 1,1,0,6, 1,1,0,3, 0, 1-BYP,'h08,0,0,3);
    tbl[6]  = mk(1,3,0,0,0, 1-BYP,1,0,6, 0,0,0,0, 0, 0,(BYP != 0) ? 'h40 : 'h00,0,0,S);
    tbl[7]  = mk(0,0,0,0,0, 1,1,0,2, 1,1,0,6, 0, 0,'h40,0,0,S);
    tbl[8]  = mk(0,0,0,0,0, 1,1,0,2, 0,0,0,0, 0, 0,'h04,0,0,S);
    tbl[9]  = mk(0,0,0,0,0, 0,0,0,0, 1,1,0,2, 0, 0,'h04,0,0,S);
    tbl[10] = mk(0,0,1,2,0, 1,0,0,0, 0,0,0,0, 0, 1,'h04,0,0,S);
    tbl[11] = mk(0,0,0,2,0, 0,0,0,0, 0,0,0,0, 0, 0,'h04,0,0,T);
    tbl[12] = mk(0,0,0,2,0, 0,0,0,0, 1,1,0,2, 0, 0,'h04,0,0,T);
    tbl[13] = mk(0,0,1,2,0, 0,0,0,0, 0,0,0,0, 0, 0,'h00,0,0,T);
    tbl[14] = mk(0,0,0,0,0, 1,0,1,0, 0,0,0,0, 0, 0,'h00,0,0,T);
    tbl[15] = mk(0,0,0,0,1, 1,0,0,0, 0,0,0,0, 0, 1,'h00,1,0,T);
    tbl[16] = mk(0,0,0,0,1, 1,0,0,0, 1,0,1,0, 0, 1-BYP,'h00,1,0,T+1);
    tbl[17] = mk(0,0,0,0,1, 1-BYP,0,0,0, 0,0,0,0, 0, 0,'h00,0,0,U);
    tbl[18] = mk(0,0,0,0,0, 1,0,1,0, 0,0,0,0, 0, 0,'h00,0,0,U);
    tbl[19] = mk(0,0,0,0,0, 1,0,1,0, 1,0,1,0, 0, 0,'h00,1,0,U);
    tbl[20] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0, 0,'h00,1,0,U);
    tbl[21] = mk(0,0,0,0,0, 0,0,0,0, 1,0,1,0, 0, 0,'h00,1,0,U);
    tbl[22] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0, 0,'h00,0,0,U);
    tbl[23] = mk(0,0,0,0,0, 1,1,0,5, 0,0,0,0, 0, 0,'h00,0,0,U);
    tbl[24] = mk(0,0,0,0,0, 1,1,0,5, 0,0,0,0, 0, 0,'h20,0,0,U);
    tbl[25] = mk(0,0,0,0,0, 1,1,0,5, 0,0,0,0, 0, 0,'h20,0,0,U);
    tbl[26] = mk(0,0,0,0,0, 1,1,0,5, 0,0,0,0, 0, 0,'h20,0,0,U);
    tbl[27] = mk(0,0,0,0,0, 0,0,0,0, 1,1,0,5, 0, 0,'h20,0,1,U);
    tbl[28] = mk(0,0,0,0,0, 0,0,0,0, 1,1,0,5, 0, 0,'h20,0,1,U);
    tbl[29] = mk(0,0,0,0,0, 0,0,0,0, 1,1,0,5, 0, 0,'h20,0,1,U);
    tbl[30] = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0, 0,'h00,0,1,U);
    tbl[31] = mk(0,0,0,0,0, 1,1,1,2, 0,0,0,0, 0, 0,'h00,0,1,U);
    tbl[32] = mk(0,0,0,0,0, 1,1,0,3, 0,0,0,0, 0, 0,'h04,1,1,U);
    tbl[33] = mk(0,0,0,0,0, 1,1,0,5, 0,0,0,0, 0, 0,'h0C,1,1,U);
    tbl[34] = mk(0,0,0,0,0, 1,1,0,1, 1,1,0,2, 1, 0,'h2C,1,1,U);
    tbl[35] = mk(1,3,0,0,0, 0,0,0,0, 0,0,0,0, 0, 0,'h00,0,1,U);

    apply(idle);
    repeat (2) @(negedge clk);
    check_all(-1, idle);
    reset_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check_all(i, tbl[i]);
    end

    // Asynchronous reset in the middle of a stall clears everything without a clock edge.
    @(negedge clk);
    apply(mk(0,0,0,0,0, 1,1,0,4, 0,0,0,0, 0, 0,0,0,0,0));
    @(negedge clk);
    apply(mk(1,4,0,0,0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0,0));
    #1;
    check("h1_stall", 0, 32'(sb_if.dep_stall), 32'd1);
    @(negedge clk);
    #1;
    check("h1_sc_before", 0, 32'(sb_if.stall_cycles), 32'(U + 1));
    reset_n = 1'b0;
    #1;
    check("h1_rst_stall", 0, 32'(sb_if.dep_stall), 32'd0);
    check("h1_rst_sc", 0, 32'(sb_if.stall_cycles), 32'd0);
    check("h1_rst_busy", 0, 32'(sb_if.busy_vec), 32'd0);
    check("h1_rst_err", 0, 32'(sb_if.sb_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("h1_post_stall", 0, 32'(sb_if.dep_stall), 32'd0);

    // Underflow on R0 sets the sticky error; a flush cycle keeps it and still counts its stall.
    @(negedge clk);
    apply(mk(0,0,0,0,0, 0,0,0,0, 1,1,0,0, 0, 0,0,0,0,0));
    @(negedge clk);
    apply(mk(0,0,0,0,0, 1,1,0,7, 0,0,0,0, 0, 0,0,0,0,0));
    #1;
    check("h2_unf_err", 0, 32'(sb_if.sb_err), 32'd1);
    check("h2_unf_busy", 0, 32'(sb_if.busy_vec), 32'd0);
    @(negedge clk);
    apply(mk(0,0,1,7,0, 1,1,0,7, 0,0,0,0, 1, 0,0,0,0,0));
    #1;
    check("h2_fl_stall", 0, 32'(sb_if.dep_stall), 32'd1);
    check("h2_fl_busy", 0, 32'(sb_if.busy_vec), 32'h80);
    @(negedge clk);
    apply(idle);
    #1;
    check("h2_post_busy", 0, 32'(sb_if.busy_vec), 32'd0);
    check("h2_post_sc", 0, 32'(sb_if.stall_cycles), 32'd1);
    check("h2_post_err", 0, 32'(sb_if.sb_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised register-dependency scoreboard for the pipelined LC-3b core. It replaces per-stage destination comparison with per-register pending-write counters, so pipeline depth no longer sets the logic. It sits beside decode: it drives the decode-stage stall, counts issues into execute, and counts retirements at writeback. Condition-code writers are tracked the same way for branches, and a saturating stall-cycle counter is provided for performance debug.

## Interface
- NUM_REGS, 8: number of architectural registers tracked.
- REG_W, $clog2(NUM_REGS): register index width.
- MAX_INFLIGHT, 3: maximum simultaneous pending writers per register or CC; counter width CNT_W = $clog2(MAX_INFLIGHT+1).
- STALL_CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  core clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sr1_needed, sr2_needed  in  1  decode instruction reads sr1 / sr2.
- sr1, sr2  in  REG_W  decode source register indices.
- de_br_op  in  1  decode instruction is a conditional branch and reads CC.
- issue_valid  in  1  decode instruction would advance into execute this cycle.
- issue_ld_reg, issue_ld_cc  in  1  issuing instruction writes a register / CC.
- issue_dr  in  REG_W  issuing instruction destination.
- retire_valid  in  1  writeback commits an instruction this cycle.
- retire_ld_reg, retire_ld_cc  in  1  retiring instruction writes a register / CC.
- retire_dr  in  REG_W  retiring destination.
- flush  in  1  pipeline squash; all in-flight writers are discarded.
- dep_stall  out  1  hold decode this cycle.
- busy_vec  out  NUM_REGS  bit i set when reg_cnt[i] != 0.
- cc_pending  out  1  cc_cnt != 0.
- sb_err  out  1  sticky: a counter overflow or underflow was attempted.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with dep_stall = 1.

## Operation
- State:
  - reg_cnt[0..NUM_REGS-1] and cc_cnt, each CNT_W bits.
  - sb_err.
  - stall_cycles.
- dep_stall is combinational: (sr1_needed & reg_cnt[sr1]!=0) | (sr2_needed & reg_cnt[sr2]!=0) | (de_br_op & cc_cnt!=0).
- Issue handshake:
  - issue_fire = issue_valid & ~dep_stall & ~flush.
  - A stalled issue is never counted.
  - issue_fire & issue_ld_reg increments reg_cnt[issue_dr].
  - issue_fire & issue_ld_cc increments cc_cnt.
- Retire:
  - retire_fire = retire_valid & ~flush.
  - retire_fire & retire_ld_reg decrements reg_cnt[retire_dr].
  - retire_fire & retire_ld_cc decrements cc_cnt.
- Simultaneous increment and decrement of the same counter: the value is unchanged and no error is raised.
- Saturation:
  - An increment of a counter at MAX_INFLIGHT holds the counter and sets sb_err.
  - A decrement of a counter at 0 holds the counter and sets sb_err.
- Flush:
  - Clears every reg_cnt and cc_cnt next edge.
  - Same-cycle issue and retire are ignored.
  - Upstream guarantees that every instruction older than the squash point has retired before or in the flush cycle. Because retire is ignored under flush, an older instruction retiring in the flush cycle is not decremented; its counter is cleared by the flush instead.
  - sb_err and stall_cycles are not affected by flush.
- stall_cycles increments each cycle dep_stall = 1 and saturates at all-ones.
- Register file writes at the edge, so a retiring writer does not resolve a stall in the same cycle. The exception is the Configuration feature below.

## Timing
- Reset (async assert, sync-safe deassert): all counters 0, sb_err = 0, stall_cycles = 0. Consequently dep_stall = 0, busy_vec = 0, cc_pending = 0.
- dep_stall has zero-cycle latency from sr*/de_br_op inputs and current state.
- Counter effects are visible in dep_stall and busy_vec one cycle after issue/retire.
- Back-to-back dependent pair (producer issues at cycle N, consumer decoded at N+1): stall holds until the cycle after the producer's retire cycle.
- Reset mid-operation discards all counts immediately, without waiting for an edge.

## Configuration
- HAZARD_RETIRE_BYPASS_EN defined:
  - A source counter equal to 1 whose matching retire_fire occurs this cycle (same dr, or retire_ld_cc for CC) is treated as clear for dep_stall.
  - This is for the write-through register file variant, where decode reads the writeback value.
- Undefined: dep_stall depends on counter state only, as above.

## Test plan
- Reset, then sr1=3 sr1_needed=1, with no issues -> dep_stall=0, busy_vec=8'h00, stall_cycles=0.
- Issue ld_reg dr=3 at cycle 1; decode sr1=3 at cycle 2; retire dr=3 at cycle 5 -> dep_stall=1 for cycles 2–5, 0 at cycle 6, stall_cycles=4. With HAZARD_RETIRE_BYPASS_EN -> dep_stall 0 at cycle 5, stall_cycles=3.
- Two writers of R2 issued, one retires, then decode reads sr2=2 with sr2_needed=1 -> reg_cnt[2]=1, dep_stall=1. After the second retire -> dep_stall=0. With sr2_needed=0 -> dep_stall=0 throughout.
- Issue ld_cc, then de_br_op=1 -> dep_stall=1 until CC retire. Same-cycle issue ld_cc and retire ld_cc at cc_cnt=1 -> cc_cnt stays 1, sb_err=0.
- Four issues to R5 without retire (MAX_INFLIGHT=3) -> reg_cnt[5]=3, sb_err=1. A retire to R0 at count 0 also sets sb_err, which stays set until reset.
- With busy_vec=8'h2C and cc_pending=1, assert flush together with issue dr=1 -> next cycle busy_vec=0, cc_pending=0, and R1 not counted. Then deassert reset_n mid-stall -> dep_stall=0 and stall_cycles=0 immediately.
